// File: rtl/nl2_cln_burst_arb.sv
// nl2_cln_burst_arb: round-robin burst arbiter sharing one valid/ready channel.
// A burst keeps the grant from its first accepted beat until its last beat is accepted.
// Optional build macro NL2_CLN_BURST_ARB_OUTREG_EN: adds a 2-entry skid register on the
// output (registered out_*, 1-cycle latency); without it the output path is combinational.
module nl2_cln_burst_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = 64,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic              out_last,
    output logic [DW-1:0]     out_data,
    output logic [IDW-1:0]    out_id,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;
    localparam logic [IDW-1:0] PivotRst = IDW'(NREQ - 1);

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] pivot_q, pivot_d;
    logic [IDW-1:0] lock_idx_q, lock_idx_d;

    logic [IDW-1:0] sel;
    logic [IDW-1:0] cand;
    logic           found;
    logic           sel_valid;
    logic           sel_last;
    logic [DW-1:0]  sel_data;
    logic           in_ready;
    logic           in_xfer;

    // Pick the requester: the lock owner, or the first valid one after the pivot.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        if (state_q == StLocked) begin
            sel = lock_idx_q;
        end else begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                cand = IDW'((pivot_q + k) % NREQ);
                if (!found && req_valid[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    // Mux the selected requester's beat.
    always_comb begin
        sel_valid = req_valid[sel];
        sel_last  = req_last[sel];
        sel_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == IDW'(i)) begin
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    assign in_xfer = sel_valid & in_ready;

    // Grant bookkeeping: lock on a non-last first beat, release on the last beat.
    always_comb begin
        state_d    = state_q;
        pivot_d    = pivot_q;
        lock_idx_d = lock_idx_q;
        if (in_xfer) begin
            case (state_q)
                StIdle: begin
                    pivot_d = sel;
                    if (!sel_last) begin
                        state_d    = StLocked;
                        lock_idx_d = sel;
                    end
                end
                StLocked: begin
                    if (sel_last) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_q    <= StIdle;
            pivot_q    <= PivotRst;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            pivot_q    <= pivot_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign busy = (state_q == StLocked);

    // Only the selected requester ever sees ready.
    always_comb begin
        req_ready      = '0;
        req_ready[sel] = in_xfer;
    end

`ifdef NL2_CLN_BURST_ARB_OUTREG_EN

    // Entry 0 drives the outputs; entry 1 catches a beat while entry 0 is stalled.
    logic           v0_q, v0_d, v1_q, v1_d;
    logic           last0_q, last0_d, last1_q, last1_d;
    logic [DW-1:0]  data0_q, data0_d, data1_q, data1_d;
    logic [IDW-1:0] id0_q, id0_d, id1_q, id1_d;
    logic           push;
    logic           pop;

    assign in_ready = ~v1_q;
    assign push     = in_xfer;
    assign pop      = v0_q & out_ready;

    // Skid next-state; emptied entries are zeroed so idle outputs read 0.
    always_comb begin
        v0_d    = v0_q;
        v1_d    = v1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        id0_d   = id0_q;
        id1_d   = id1_q;
        if (!v0_q) begin
            if (push) begin
                v0_d    = 1'b1;
                last0_d = sel_last;
                data0_d = sel_data;
                id0_d   = sel;
            end
        end else if (!v1_q) begin
            if (pop && push) begin
                last0_d = sel_last;
                data0_d = sel_data;
                id0_d   = sel;
            end else if (pop) begin
                v0_d    = 1'b0;
                last0_d = 1'b0;
                data0_d = '0;
                id0_d   = '0;
            end else if (push) begin
                v1_d    = 1'b1;
                last1_d = sel_last;
                data1_d = sel_data;
                id1_d   = sel;
            end
        end else if (pop) begin
            last0_d = last1_q;
            data0_d = data1_q;
            id0_d   = id1_q;
            v1_d    = 1'b0;
            last1_d = 1'b0;
            data1_d = '0;
            id1_d   = '0;
        end
    end

    // Skid registers; reset clears both entries.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
            id0_q   <= '0;
            id1_q   <= '0;
        end else begin
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            id0_q   <= id0_d;
            id1_q   <= id1_d;
        end
    end

    assign out_valid = v0_q;
    assign out_last  = last0_q;
    assign out_data  = data0_q;
    assign out_id    = id0_q;

`else

    // Zero-latency path; ready must not feed back into valid.
    assign in_ready  = out_ready;
    assign out_valid = sel_valid;
    assign out_last  = sel_valid & sel_last;
    assign out_data  = sel_valid ? sel_data : '0;
    assign out_id    = sel_valid ? sel : '0;

`endif

endmodule
